// File: rtl/memory_stage_if.sv
// Data-memory request/grant/response bus between memory_stage and the data memory.
interface memory_stage_if;
  logic        dmem_req_v;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_v, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_v, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes ALU results through and performs loads/stores
// over a request/grant/response data-memory bus, stalling upstream while busy.
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 execute_v,
  input  logic [4:0]           execute_rd,
  input  logic [31:0]          execute_result,
  input  logic [31:0]          execute_data,
  input  logic                 execute_ld_v,
  input  logic                 execute_st_v,
  input  logic [2:0]           execute_funct3,
  input  logic                 execute_wb_v,
  output logic                 memory_stall_v,
  memory_stage_if.master       dmem,
  output logic                 memory_v,
  output logic [4:0]           memory_rd,
  output logic [31:0]          memory_result,
  output logic                 memory_wb_v,
  output logic                 memory_misaligned_v,
  output logic                 memory_fault_v
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d, we_q, we_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [1:0]         lane_q, lane_d, size_q, size_d;
  logic               uns_q, uns_d, wb_q, wb_d;
  logic [4:0]         rd_q, rd_d, mrd_q, mrd_d;
  logic [31:0]        mres_q, mres_d;
  logic               mv_q, mv_d, mwb_q, mwb_d, mis_q, mis_d, flt_q, flt_d;

  logic               ex_mem_op, ex_misaligned, timed_out;
  logic [3:0]         ex_be;
  logic [31:0]        ex_wdata, rd_shifted, load_data;

  // Decode of the instruction offered by execute (funct3[1:0]: 00 B, 01 H, else W).
  always_comb begin
    ex_mem_op     = execute_ld_v | execute_st_v;
    ex_misaligned = ((execute_funct3[1:0] == 2'b01) && execute_result[0]) ||
                    (execute_funct3[1] && (execute_result[1:0] != 2'b00));
    unique case (execute_funct3[1:0])
      2'b00: begin
        ex_be    = 4'(4'b0001 << execute_result[1:0]);
        ex_wdata = {4{execute_data[7:0]}};
      end
      2'b01: begin
        ex_be    = 4'(4'b0011 << execute_result[1:0]);
        ex_wdata = {2{execute_data[15:0]}};
      end
      default: begin
        ex_be    = 4'b1111;
        ex_wdata = execute_data;
      end
    endcase
  end

  // Align the returned word to the addressed lane and extend to 32 bits.
  always_comb begin
    rd_shifted = dmem.dmem_rdata_i >> {lane_q, 3'b000};
    unique case (size_q)
      2'b00:   load_data = uns_q ? {24'd0, rd_shifted[7:0]}
                                 : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_data = uns_q ? {16'd0, rd_shifted[15:0]}
                                 : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

  assign timed_out      = (cnt_q >= CNT_LAST);
  assign memory_stall_v = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    mrd_d   = mrd_q;
    mres_d  = mres_q;
    mv_d    = 1'b0;
    mwb_d   = 1'b0;
    mis_d   = 1'b0;
    flt_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (execute_v && !ex_mem_op) begin
          mv_d   = 1'b1;
          mres_d = execute_result;
          mrd_d  = execute_rd;
          mwb_d  = execute_wb_v;
        end else if (execute_v && ex_misaligned) begin
          mv_d   = 1'b1;
          mis_d  = 1'b1;
          mres_d = execute_result;
          mrd_d  = execute_rd;
        end else if (execute_v) begin
          state_d = REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = execute_st_v;
          addr_d  = {execute_result[31:2], 2'b00};
          wdata_d = ex_wdata;
          be_d    = ex_be;
          lane_d  = execute_result[1:0];
          size_d  = execute_funct3[1:0];
          uns_d   = execute_funct3[2];
          wb_d    = execute_wb_v;
          rd_d    = execute_rd;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.dmem_gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? IDLE : RESP;
          if (we_q) begin
            mv_d  = 1'b1;
            mrd_d = rd_q;
          end
        end else if (timed_out) begin
          req_d   = 1'b0;
          mv_d    = 1'b1;
          flt_d   = 1'b1;
          mrd_d   = rd_q;
          state_d = IDLE;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.dmem_rvalid_i) begin
          mv_d    = 1'b1;
          mres_d  = load_data;
          mrd_d   = rd_q;
          mwb_d   = wb_q;
          state_d = IDLE;
        end else if (timed_out) begin
          mv_d    = 1'b1;
          flt_d   = 1'b1;
          mrd_d   = rd_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wb_q    <= 1'b0;
      rd_q    <= '0;
      mrd_q   <= '0;
      mres_q  <= '0;
      mv_q    <= 1'b0;
      mwb_q   <= 1'b0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      mrd_q   <= mrd_d;
      mres_q  <= mres_d;
      mv_q    <= mv_d;
      mwb_q   <= mwb_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
    end
  end

  assign dmem.dmem_req_v   = req_q;
  assign dmem.dmem_we      = we_q;
  assign dmem.dmem_addr    = addr_q;
  assign dmem.dmem_wdata   = wdata_q;
  assign dmem.dmem_be      = be_q;
  assign memory_v            = mv_q;
  assign memory_rd           = mrd_q;
  assign memory_result       = mres_q;
  assign memory_wb_v         = mwb_q;
  assign memory_misaligned_v = mis_q;
  assign memory_fault_v      = flt_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: passthrough, loads, stores, misalignment,
// timeout and mid-transaction reset, against hand-computed expectations.
module tb_memory_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        execute_v, execute_ld_v, execute_st_v, execute_wb_v;
  logic [4:0]  execute_rd;
  logic [31:0] execute_result, execute_data;
  logic [2:0]  execute_funct3;
  logic        memory_stall_v, memory_v, memory_wb_v, memory_misaligned_v, memory_fault_v;
  logic [4:0]  memory_rd;
  logic [31:0] memory_result;

  int checks = 0;
  int errors = 0;

  memory_stage_if dmem_bus ();

  memory_stage #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .execute_v           (execute_v),
    .execute_rd          (execute_rd),
    .execute_result      (execute_result),
    .execute_data        (execute_data),
    .execute_ld_v        (execute_ld_v),
    .execute_st_v        (execute_st_v),
    .execute_funct3      (execute_funct3),
    .execute_wb_v        (execute_wb_v),
    .memory_stall_v      (memory_stall_v),
    .dmem                (dmem_bus),
    .memory_v            (memory_v),
    .memory_rd           (memory_rd),
    .memory_result       (memory_result),
    .memory_wb_v         (memory_wb_v),
    .memory_misaligned_v (memory_misaligned_v),
    .memory_fault_v      (memory_fault_v)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] res, input logic [31:0] dat,
                       input logic wb);
    execute_v      = v;
    execute_ld_v   = ld;
    execute_st_v   = st;
    execute_funct3 = f3;
    execute_rd     = rd;
    execute_result = res;
    execute_data   = dat;
    execute_wb_v   = wb;
  endtask

  task automatic bus(input logic gnt, input logic rv, input logic [31:0] rdata);
    dmem_bus.dmem_gnt_i    = gnt;
    dmem_bus.dmem_rvalid_i = rv;
    dmem_bus.dmem_rdata_i  = rdata;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    bus(1'b0, 1'b0, 32'd0);
    tick();
    tick();
    chk("rst_mv", 32'(memory_v), 32'd0);
    chk("rst_req", 32'(dmem_bus.dmem_req_v), 32'd0);
    chk("rst_stall", 32'(memory_stall_v), 32'd0);
    chk("rst_res", memory_result, 32'd0);
    rst_i = 1'b0;
    tick();

    // ALU passthrough, back to back
    drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd5, 32'h1234_5678, 32'd0, 1'b1);
    tick();
    chk("alu_mv", 32'(memory_v), 32'd1);
    chk("alu_res", memory_result, 32'h1234_5678);
    chk("alu_rd", 32'(memory_rd), 32'd5);
    chk("alu_wb", 32'(memory_wb_v), 32'd1);
    chk("alu_req", 32'(dmem_bus.dmem_req_v), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd7, 32'h0000_A5A5, 32'd0, 1'b0);
    tick();
    chk("alu2_mv", 32'(memory_v), 32'd1);
    chk("alu2_res", memory_result, 32'h0000_A5A5);
    chk("alu2_wb", 32'(memory_wb_v), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    chk("idle_mv", 32'(memory_v), 32'd0);
    chk("idle_hold", memory_result, 32'h0000_A5A5);

    // LB at 0x103 with a held ALU op behind it
    drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd3, 32'h0000_0103, 32'd0, 1'b1);
    tick();
    chk("lb_req", 32'(dmem_bus.dmem_req_v), 32'd1);
    chk("lb_addr", dmem_bus.dmem_addr, 32'h0000_0100);
    chk("lb_we", 32'(dmem_bus.dmem_we), 32'd0);
    chk("lb_stall1", 32'(memory_stall_v), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 5'd9, 32'h0000_0077, 32'd0, 1'b1);
    bus(1'b1, 1'b0, 32'd0);
    tick();
    chk("lb_req_drop", 32'(dmem_bus.dmem_req_v), 32'd0);
    chk("lb_stall2", 32'(memory_stall_v), 32'd1);
    chk("lb_mv_wait", 32'(memory_v), 32'd0);
    bus(1'b0, 1'b1, 32'h80AA_BBCC);
    tick();
    bus(1'b0, 1'b0, 32'd0);
    chk("lb_mv", 32'(memory_v), 32'd1);
    chk("lb_res", memory_result, 32'hFFFF_FF80);
    chk("lb_rd", 32'(memory_rd), 32'd3);
    chk("lb_wb", 32'(memory_wb_v), 32'd1);
    chk("lb_stall0", 32'(memory_stall_v), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("held_mv", 32'(memory_v), 32'd1);
    chk("held_res", memory_result, 32'h0000_0077);
    chk("held_rd", 32'(memory_rd), 32'd9);

    // SH at 0x202, grant delayed 4 cycles
    drive(1'b1, 1'b0, 1'b1, 3'b001, 5'd4, 32'h0000_0202, 32'hDEAD_BEEF, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("sh_req", 32'(dmem_bus.dmem_req_v), 32'd1);
      chk("sh_addr", dmem_bus.dmem_addr, 32'h0000_0200);
      chk("sh_be", 32'(dmem_bus.dmem_be), 32'h0000_000C);
      chk("sh_wdata", dmem_bus.dmem_wdata, 32'hBEEF_BEEF);
      chk("sh_we", 32'(dmem_bus.dmem_we), 32'd1);
      if (i == 4) bus(1'b1, 1'b0, 32'd0);
      tick();
    end
    bus(1'b0, 1'b0, 32'd0);
    chk("sh_mv", 32'(memory_v), 32'd1);
    chk("sh_wb", 32'(memory_wb_v), 32'd0);
    chk("sh_req_drop", 32'(dmem_bus.dmem_req_v), 32'd0);
    chk("sh_stall", 32'(memory_stall_v), 32'd0);

    // SB at 0x301 with immediate grant: stall only one cycle
    drive(1'b1, 1'b0, 1'b1, 3'b000, 5'd2, 32'h0000_0301, 32'h1234_565A, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("sb_be", 32'(dmem_bus.dmem_be), 32'h0000_0002);
    chk("sb_wdata", dmem_bus.dmem_wdata, 32'h5A5A_5A5A);
    chk("sb_addr", dmem_bus.dmem_addr, 32'h0000_0300);
    bus(1'b1, 1'b0, 32'd0);
    tick();
    bus(1'b0, 1'b0, 32'd0);
    chk("sb_mv", 32'(memory_v), 32'd1);
    chk("sb_stall", 32'(memory_stall_v), 32'd0);

    // Misaligned LW at 0x001
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd6, 32'h0000_0001, 32'd0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("mis_mv", 32'(memory_v), 32'd1);
    chk("mis_flag", 32'(memory_misaligned_v), 32'd1);
    chk("mis_wb", 32'(memory_wb_v), 32'd0);
    chk("mis_res", memory_result, 32'h0000_0001);
    chk("mis_req", 32'(dmem_bus.dmem_req_v), 32'd0);
    chk("mis_stall", 32'(memory_stall_v), 32'd0);
    tick();
    chk("mis_clear", 32'(memory_misaligned_v), 32'd0);

    // Timeout: grant never arrives, fault 8 cycles after request start
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd8, 32'h0000_0040, 32'd0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("to_wait_mv", 32'(memory_v), 32'd0);
      chk("to_wait_req", 32'(dmem_bus.dmem_req_v), 32'd1);
      tick();
    end
    chk("to_mv", 32'(memory_v), 32'd1);
    chk("to_fault", 32'(memory_fault_v), 32'd1);
    chk("to_wb", 32'(memory_wb_v), 32'd0);
    chk("to_req", 32'(dmem_bus.dmem_req_v), 32'd0);
    chk("to_stall", 32'(memory_stall_v), 32'd0);
    bus(1'b1, 1'b1, 32'hCAFE_F00D);
    tick();
    bus(1'b0, 1'b0, 32'd0);
    chk("stray_mv", 32'(memory_v), 32'd0);
    chk("stray_fault", 32'(memory_fault_v), 32'd0);
    chk("stray_res", memory_result, 32'h0000_0001);
    chk("stray_stall", 32'(memory_stall_v), 32'd0);

    // Reset while waiting in RESP
    drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd11, 32'h0000_0080, 32'd0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    bus(1'b1, 1'b0, 32'd0);
    tick();
    bus(1'b0, 1'b0, 32'd0);
    chk("rr_stall", 32'(memory_stall_v), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rr_stall0", 32'(memory_stall_v), 32'd0);
    chk("rr_req", 32'(dmem_bus.dmem_req_v), 32'd0);
    chk("rr_mv", 32'(memory_v), 32'd0);
    chk("rr_res", memory_result, 32'd0);

    // LHU at 0x002 after reset
    drive(1'b1, 1'b1, 1'b0, 3'b101, 5'd10, 32'h0000_0002, 32'd0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("lhu_addr", dmem_bus.dmem_addr, 32'h0000_0000);
    bus(1'b1, 1'b0, 32'd0);
    tick();
    bus(1'b0, 1'b1, 32'h8001_0000);
    tick();
    bus(1'b0, 1'b0, 32'd0);
    chk("lhu_mv", 32'(memory_v), 32'd1);
    chk("lhu_res", memory_result, 32'h0000_8001);
    chk("lhu_rd", 32'(memory_rd), 32'd10);

    // Signed LH at 0x002 for contrast
    drive(1'b1, 1'b1, 1'b0, 3'b001, 5'd12, 32'h0000_0002, 32'd0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
    bus(1'b1, 1'b0, 32'd0);
    tick();
    bus(1'b0, 1'b1, 32'h8001_0000);
    tick();
    bus(1'b0, 1'b0, 32'd0);
    chk("lh_res", memory_result, 32'hFFFF_8001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
